// File: rtl/dds_serial_rx.sv
// Serial-load responder for the DDS control interface. It synchronizes the
// W_CLK/FQ_UD/DATA/RESET lines, assembles a 40-bit frame and commits its fields on FQ_UD.
module dds_serial_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        W_CLK,
    input  logic        FQ_UD,
    input  logic        DATA,
    input  logic        RESET,
    output logic [31:0] freq_word,
    output logic [1:0]  ctrl_bits,
    output logic        power_down,
    output logic [4:0]  phase_word,
    output logic        word_valid,
    output logic        frame_err,
    output logic [5:0]  bit_count,
    output logic        busy
);

    localparam logic [5:0] FRAME_CNT = 6'(FRAME_BITS);
    localparam logic [5:0] COUNT_MAX = 6'd63;

    logic [SYNC_STAGES-1:0] wclkSync_q, fqudSync_q, dataSync_q, rstSync_q;
    logic                   wclkDly_q, fqudDly_q;

    logic [FRAME_BITS-1:0]  shreg_q, shreg_d;
    logic [5:0]             count_q, count_d;
    logic [31:0]            freq_q, freq_d;
    logic [1:0]             ctrl_q, ctrl_d;
    logic                   pd_q, pd_d;
    logic [4:0]             phase_q, phase_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;

    logic wclkSyn, fqudSyn, dataSyn, rstSyn;
    logic wclkRise, fqudRise;

    assign wclkSyn  = wclkSync_q[SYNC_STAGES-1];
    assign fqudSyn  = fqudSync_q[SYNC_STAGES-1];
    assign dataSyn  = dataSync_q[SYNC_STAGES-1];
    assign rstSyn   = rstSync_q[SYNC_STAGES-1];
    assign wclkRise = wclkSyn & ~wclkDly_q;
    assign fqudRise = fqudSyn & ~fqudDly_q;

    // Edge-detect delay registers track even under DDS reset, so a line that is
    // already high when RESET drops never produces a spurious edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wclkSync_q <= '0;
            fqudSync_q <= '0;
            dataSync_q <= '0;
            rstSync_q  <= '0;
            wclkDly_q  <= 1'b0;
            fqudDly_q  <= 1'b0;
        end else begin
            wclkSync_q <= {wclkSync_q[SYNC_STAGES-2:0], W_CLK};
            fqudSync_q <= {fqudSync_q[SYNC_STAGES-2:0], FQ_UD};
            dataSync_q <= {dataSync_q[SYNC_STAGES-2:0], DATA};
            rstSync_q  <= {rstSync_q[SYNC_STAGES-2:0], RESET};
            wclkDly_q  <= wclkSyn;
            fqudDly_q  <= fqudSyn;
        end
    end

    // A coincident W_CLK edge is shifted in before the FQ_UD count check and commit.
    always_comb begin
        shreg_d = shreg_q;
        count_d = count_q;
        freq_d  = freq_q;
        ctrl_d  = ctrl_q;
        pd_d    = pd_q;
        phase_d = phase_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (rstSyn) begin
            shreg_d = '0;
            count_d = '0;
            freq_d  = '0;
            ctrl_d  = '0;
            pd_d    = 1'b0;
            phase_d = '0;
        end else begin
            if (wclkRise) begin
                shreg_d = {dataSyn, shreg_q[FRAME_BITS-1:1]};
                if (count_q != COUNT_MAX) begin
                    count_d = count_q + 6'd1;
                end
            end
            if (fqudRise) begin
                if (count_d == FRAME_CNT) begin
                    freq_d  = shreg_d[31:0];
                    ctrl_d  = shreg_d[33:32];
                    pd_d    = shreg_d[34];
                    phase_d = shreg_d[39:35];
                    valid_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q <= '0;
            count_q <= '0;
            freq_q  <= '0;
            ctrl_q  <= '0;
            pd_q    <= 1'b0;
            phase_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            count_q <= count_d;
            freq_q  <= freq_d;
            ctrl_q  <= ctrl_d;
            pd_q    <= pd_d;
            phase_q <= phase_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign freq_word  = freq_q;
    assign ctrl_bits  = ctrl_q;
    assign power_down = pd_q;
    assign phase_word = phase_q;
    assign word_valid = valid_q;
    assign frame_err  = err_q;
    assign bit_count  = count_q;
    assign busy       = (count_q != 6'd0);

endmodule

// File: tb/tb_dds_serial_rx.sv
// Self-checking bench for dds_serial_rx: drives the serial DDS protocol and compares
// against a bit-queue reference model that decodes fields from the received bit list.
module tb_dds_serial_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        W_CLK, FQ_UD, DATA, RESET;
    logic [31:0] freq_word;
    logic [1:0]  ctrl_bits;
    logic        power_down;
    logic [4:0]  phase_word;
    logic        word_valid, frame_err;
    logic [5:0]  bit_count;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    bit          modelBits[$];
    logic [31:0] mFreq  = '0;
    logic [1:0]  mCtrl  = '0;
    logic        mPd    = 1'b0;
    logic [4:0]  mPhase = '0;

    dds_serial_rx #(.SYNC_STAGES(2), .FRAME_BITS(40)) dut (
        .clk(clk), .reset(reset), .W_CLK(W_CLK), .FQ_UD(FQ_UD), .DATA(DATA), .RESET(RESET),
        .freq_word(freq_word), .ctrl_bits(ctrl_bits), .power_down(power_down),
        .phase_word(phase_word), .word_valid(word_valid), .frame_err(frame_err),
        .bit_count(bit_count), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] packFrame(input logic [31:0] f, input logic [1:0] c,
                                              input logic p, input logic [4:0] ph);
        return {ph, p, c, f};
    endfunction

    function automatic int expCount();
        return (modelBits.size() > 63) ? 63 : modelBits.size();
    endfunction

    function automatic void modelClear();
        modelBits.delete();
        mFreq  = '0;
        mCtrl  = '0;
        mPd    = 1'b0;
        mPhase = '0;
    endfunction

    // Reference decode: bit i of the received list is W<i>.
    task automatic modelFqud(output bit expValid);
        expValid = (modelBits.size() == 40);
        if (expValid) begin
            for (int i = 0; i < 32; i++) mFreq[i] = modelBits[i];
            mCtrl = {modelBits[33], modelBits[32]};
            mPd   = modelBits[34];
            for (int i = 0; i < 5; i++) mPhase[i] = modelBits[35+i];
        end
        modelBits.delete();
    endtask

    // One W_CLK period of 4 clk: low 2, high 2; DATA set at the start of the low phase.
    task automatic sendBit(input bit b);
        DATA  = b;
        W_CLK = 1'b0;
        repeat (2) @(negedge clk);
        W_CLK = 1'b1;
        repeat (2) @(negedge clk);
        modelBits.push_back(b);
    endtask

    task automatic sendBits(input logic [63:0] word, input int n);
        for (int i = 0; i < n; i++) sendBit(word[i]);
        W_CLK = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Raises FQ_UD for 2 clk and records pulse counts and the cycle they appeared in.
    task automatic fqudPulse(output int nValid, output int nErr, output int validAt);
        nValid  = 0;
        nErr    = 0;
        validAt = -1;
        FQ_UD   = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (word_valid) begin nValid++; validAt = k; end
            if (frame_err) nErr++;
            if (k == 2) FQ_UD = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; W_CLK = 1'b0; FQ_UD = 1'b0; DATA = 1'b0; RESET = 1'b0;
        #1;
        checks++;
        if ({freq_word, ctrl_bits, power_down, phase_word, word_valid, frame_err, bit_count, busy} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got freq=%h ctrl=%b pd=%b phase=%b cnt=%0d expected all 0",
                     freq_word, ctrl_bits, power_down, phase_word, bit_count);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bit_count !== 6'd0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release: got cnt=%0d busy=%b expected 0/0", bit_count, busy);
        end
    endtask

    task automatic test_fixed_frame();
        int nV, nE, at;
        bit expV;
        sendBits({24'd0, packFrame(32'h147AE148, 2'b00, 1'b0, 5'd0)}, 40);
        checks++;
        if (bit_count !== 6'(expCount()) || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL fixed_count: got cnt=%0d busy=%b expected %0d/1", bit_count, busy, expCount());
        end
        modelFqud(expV);
        fqudPulse(nV, nE, at);
        checks++;
        if (nV !== 1 || at !== 3 || nE !== 0 || !expV) begin
            failures++;
            $display("[TB] FAIL fixed_pulse: got valid=%0d at=%0d err=%0d expected 1 at 3, err 0", nV, at, nE);
        end
        checks++;
        if (freq_word !== mFreq || phase_word !== mPhase || freq_word !== 32'h147AE148) begin
            failures++;
            $display("[TB] FAIL fixed_fields: got freq=%h phase=%h expected %h/%h", freq_word, phase_word, mFreq, mPhase);
        end
    endtask

    task automatic test_all_fields();
        int nV, nE, at;
        bit expV;
        sendBits({24'd0, packFrame(32'hFFFFFFFF, 2'b01, 1'b1, 5'b10011)}, 40);
        modelFqud(expV);
        fqudPulse(nV, nE, at);
        checks++;
        if (nV !== 1 || nE !== 0) begin
            failures++;
            $display("[TB] FAIL fields_pulse: got valid=%0d err=%0d expected 1/0", nV, nE);
        end
        checks++;
        if (freq_word !== mFreq || ctrl_bits !== mCtrl || power_down !== mPd || phase_word !== mPhase
            || ctrl_bits !== 2'b01 || phase_word !== 5'b10011) begin
            failures++;
            $display("[TB] FAIL fields_values: got %h %b %b %b expected %h %b %b %b",
                     freq_word, ctrl_bits, power_down, phase_word, mFreq, mCtrl, mPd, mPhase);
        end
        checks++;
        if (bit_count !== 6'd0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fields_count_clear: got cnt=%0d busy=%b expected 0/0", bit_count, busy);
        end
    endtask

    task automatic test_bad_count();
        int nV, nE, at;
        bit expV;
        int lens[3] = '{39, 41, 66};
        foreach (lens[j]) begin
            sendBits({$urandom, $urandom}, (lens[j] > 64) ? 64 : lens[j]);
            for (int i = 64; i < lens[j]; i++) sendBit(1'($urandom));
            W_CLK = 1'b0;
            repeat (2) @(negedge clk);
            checks++;
            if (bit_count !== 6'(expCount())) begin
                failures++;
                $display("[TB] FAIL bad_count_%0d: got cnt=%0d expected %0d", lens[j], bit_count, expCount());
            end
            modelFqud(expV);
            fqudPulse(nV, nE, at);
            checks++;
            if (nV !== 0 || nE !== 1 || expV) begin
                failures++;
                $display("[TB] FAIL bad_pulse_%0d: got valid=%0d err=%0d expected 0/1", lens[j], nV, nE);
            end
            checks++;
            if (freq_word !== mFreq || ctrl_bits !== mCtrl || power_down !== mPd || phase_word !== mPhase) begin
                failures++;
                $display("[TB] FAIL bad_hold_%0d: got freq=%h expected %h", lens[j], freq_word, mFreq);
            end
        end
        sendBits({24'd0, packFrame(32'hA5A55A5A, 2'b10, 1'b0, 5'b01100)}, 40);
        modelFqud(expV);
        fqudPulse(nV, nE, at);
        checks++;
        if (nV !== 1 || nE !== 0 || freq_word !== mFreq || phase_word !== mPhase || ctrl_bits !== mCtrl) begin
            failures++;
            $display("[TB] FAIL bad_recover: got valid=%0d err=%0d freq=%h expected 1/0 %h", nV, nE, freq_word, mFreq);
        end
    endtask

    task automatic test_dds_reset();
        int nV, nE, at;
        bit expV;
        int pulses = 0;
        sendBits({$urandom, $urandom}, 20);
        RESET = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (word_valid || frame_err) pulses++;
            if (k == 1) begin DATA = 1'b1; W_CLK = 1'b1; end
            if (k == 4) RESET = 1'b0;
        end
        W_CLK = 1'b0;
        repeat (4) @(negedge clk);
        modelClear();
        checks++;
        if (pulses !== 0 || bit_count !== 6'd0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ddsreset_state: got pulses=%0d cnt=%0d busy=%b expected 0/0/0", pulses, bit_count, busy);
        end
        checks++;
        if ({freq_word, ctrl_bits, power_down, phase_word} !== '0) begin
            failures++;
            $display("[TB] FAIL ddsreset_fields: got freq=%h phase=%h expected 0", freq_word, phase_word);
        end
        sendBits({24'd0, packFrame(32'h13579BDF, 2'b11, 1'b1, 5'b00101)}, 40);
        modelFqud(expV);
        fqudPulse(nV, nE, at);
        checks++;
        if (nV !== 1 || nE !== 0 || freq_word !== mFreq || power_down !== mPd || phase_word !== mPhase) begin
            failures++;
            $display("[TB] FAIL ddsreset_after: got valid=%0d freq=%h expected 1 %h", nV, freq_word, mFreq);
        end
    endtask

    task automatic test_async_reset();
        int nV, nE, at;
        bit expV;
        sendBits({$urandom, $urandom}, 25);
        checks++;
        if (bit_count !== 6'd25) begin
            failures++;
            $display("[TB] FAIL async_precount: got cnt=%0d expected 25", bit_count);
        end
        reset = 1'b0;
        #1;
        modelClear();
        checks++;
        if ({freq_word, ctrl_bits, power_down, phase_word, bit_count, busy} !== '0) begin
            failures++;
            $display("[TB] FAIL async_clear: got freq=%h cnt=%0d busy=%b expected 0", freq_word, bit_count, busy);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        sendBits({24'd0, packFrame(32'hDEADBEEF, 2'b01, 1'b0, 5'b11111)}, 40);
        modelFqud(expV);
        fqudPulse(nV, nE, at);
        checks++;
        if (nV !== 1 || nE !== 0 || freq_word !== mFreq || phase_word !== mPhase) begin
            failures++;
            $display("[TB] FAIL async_after: got valid=%0d err=%0d freq=%h expected 1/0 %h", nV, nE, freq_word, mFreq);
        end
    endtask

    task automatic test_back_to_back();
        int nV, nE, at;
        bit expV;
        logic [31:0] words[2] = '{32'h00000001, 32'h80000000};
        foreach (words[j]) begin
            sendBits({24'd0, packFrame(words[j], 2'b00, 1'b0, 5'd0)}, 40);
            modelFqud(expV);
            fqudPulse(nV, nE, at);
            checks++;
            if (nV !== 1 || nE !== 0 || freq_word !== mFreq || freq_word !== words[j]) begin
                failures++;
                $display("[TB] FAIL b2b_%0d: got valid=%0d freq=%h expected 1 %h", j, nV, freq_word, words[j]);
            end
        end
    endtask

    task automatic test_random();
        int nV, nE, at, len;
        bit expV;
        for (int r = 0; r < 8; r++) begin
            len = ($urandom_range(0, 2) == 0) ? 38 + $urandom_range(0, 4) : 40;
            sendBits({$urandom, $urandom}, len);
            checks++;
            if (bit_count !== 6'(expCount())) begin
                failures++;
                $display("[TB] FAIL rand_count_%0d: got cnt=%0d expected %0d", r, bit_count, expCount());
            end
            modelFqud(expV);
            fqudPulse(nV, nE, at);
            checks++;
            if (nV !== int'(expV) || nE !== int'(!expV) || freq_word !== mFreq || ctrl_bits !== mCtrl
                || power_down !== mPd || phase_word !== mPhase) begin
                failures++;
                $display("[TB] FAIL rand_frame_%0d: len=%0d valid=%0d err=%0d freq=%h expected freq %h",
                         r, len, nV, nE, freq_word, mFreq);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed_frame();
        test_all_fields();
        test_bad_count();
        test_dds_reset();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
